// File: rtl/pattern_gen.sv
// Pattern generator: binary, gray, walking-one and LFSR sequences presented
// over a valid/ready handshake, with optional idle gap between patterns.
module pattern_gen #(
   parameter int                WIDTH     = 15,
   parameter int                STEP_GAP  = 0,
   parameter logic [WIDTH-1:0]  LFSR_TAPS = WIDTH'(15'h6000)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic             ready,
   output logic [WIDTH-1:0] pattern,
   output logic             valid,
   output logic [WIDTH-1:0] index,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

   localparam logic [1:0] M_BIN  = 2'd0;
   localparam logic [1:0] M_GRAY = 2'd1;
   localparam logic [1:0] M_WALK = 2'd2;

   // Index of the final pattern for each mode (index is WIDTH+1 bits wide).
   localparam logic [WIDTH:0] LAST_FULL = {1'b0, {WIDTH{1'b1}}};
   localparam logic [WIDTH:0] LAST_LFSR = {1'b0, {(WIDTH-1){1'b1}}, 1'b0};
   localparam logic [WIDTH:0] LAST_WALK = (WIDTH+1)'(WIDTH-1);
   localparam int             GAP_LOAD  = (STEP_GAP > 0) ? STEP_GAP - 1 : 0;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_nx;
   logic [WIDTH:0]   idx_q, idx_nx, last_idx;
   logic [1:0]       mode_q;
   logic [7:0]       gap_cnt;
   logic             load_first, advance;

   assign pattern = pat_q;
   assign index   = idx_q[WIDTH-1:0];
   assign idx_nx  = idx_q + 1'b1;

   // Final index and next pattern, both selected by the latched mode.
   always_comb begin
      last_idx = LAST_LFSR;
      pat_nx   = {pat_q[WIDTH-2:0], ^(pat_q & LFSR_TAPS)};
      case (mode_q)
         M_BIN: begin
            last_idx = LAST_FULL;
            pat_nx   = idx_nx[WIDTH-1:0];
         end
         M_GRAY: begin
            last_idx = LAST_FULL;
            pat_nx   = idx_nx[WIDTH-1:0] ^ (idx_nx[WIDTH-1:0] >> 1);
         end
         M_WALK: begin
            last_idx = LAST_WALK;
            pat_nx   = pat_q << 1;
         end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic and status outputs.
   always_comb begin
      state_d    = state_q;
      load_first = 1'b0;
      advance    = 1'b0;
      valid      = (state_q == RUN);
      busy       = (state_q == RUN) || (state_q == GAP);
      done       = (state_q == DONE);
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = RUN;
               load_first = 1'b1;
            end
         end
         RUN: begin
            if (ready) begin
               if (idx_q == last_idx) begin
                  state_d = DONE;
               end else begin
                  advance = 1'b1;
                  state_d = (STEP_GAP == 0) ? RUN : GAP;
               end
            end
         end
         GAP: begin
            if (gap_cnt == 8'd0) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: pattern, index, latched mode and gap countdown.
   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q   <= '0;
         idx_q   <= '0;
         mode_q  <= 2'd0;
         gap_cnt <= 8'd0;
      end else if (load_first) begin
         mode_q  <= mode;
         idx_q   <= '0;
         // Walking-one and LFSR start from 1, counters from 0.
         pat_q   <= mode[1] ? WIDTH'(1) : '0;
         gap_cnt <= 8'd0;
      end else if (advance) begin
         idx_q   <= idx_nx;
         pat_q   <= pat_nx;
         gap_cnt <= 8'(GAP_LOAD);
      end else if (state_q == GAP && gap_cnt != 8'd0) begin
         gap_cnt <= gap_cnt - 8'd1;
      end
   end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: a WIDTH=3 no-gap instance and a WIDTH=4
// instance with a two-cycle gap, driven from one sequence.
module tb_pattern_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start3 = 1'b0, ready3 = 1'b0;
   logic [1:0] mode3 = 2'd0;
   logic [2:0] pattern3, index3;
   logic       valid3, busy3, done3;
   logic       start4 = 1'b0, ready4 = 1'b0;
   logic [1:0] mode4 = 2'd0;
   logic [3:0] pattern4, index4;
   logic       valid4, busy4, done4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pattern_gen #(.WIDTH(3), .STEP_GAP(0), .LFSR_TAPS(3'b110)) u_d3 (
      .clk(clk), .rst(rst), .start(start3), .mode(mode3), .ready(ready3),
      .pattern(pattern3), .valid(valid3), .index(index3), .busy(busy3), .done(done3)
   );

   pattern_gen #(.WIDTH(4), .STEP_GAP(2), .LFSR_TAPS(4'b1100)) u_d4 (
      .clk(clk), .rst(rst), .start(start4), .mode(mode4), .ready(ready4),
      .pattern(pattern4), .valid(valid4), .index(index4), .busy(busy4), .done(done4)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle3(input string tag);
      chk({tag, ".pattern"}, int'(pattern3), 0);
      chk({tag, ".index"},   int'(index3),   0);
      chk({tag, ".valid"},   int'(valid3),   0);
      chk({tag, ".busy"},    int'(busy3),    0);
      chk({tag, ".done"},    int'(done3),    0);
   endtask

   initial begin
      int gray_exp [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
      int lfsr_exp [7] = '{1, 2, 5, 3, 7, 6, 4};

      // Reset state
      tick(); tick();
      rst = 1'b0;
      chk_idle3("rst3");
      chk("rst4.valid", int'(valid4), 0);
      chk("rst4.done",  int'(done4),  0);

      // Binary run: 0..7 on consecutive cycles, then DONE holding 7
      start3 = 1'b1; mode3 = 2'd0; ready3 = 1'b1;
      tick();
      start3 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("bin.pat%0d", k), int'(pattern3), k);
         chk($sformatf("bin.idx%0d", k), int'(index3),   k);
         chk($sformatf("bin.vld%0d", k), int'(valid3),   1);
         chk($sformatf("bin.bsy%0d", k), int'(busy3),    1);
         tick();
      end
      chk("bin.done",    int'(done3),    1);
      chk("bin.final",   int'(pattern3), 7);
      chk("bin.fidx",    int'(index3),   7);
      chk("bin.valid0",  int'(valid3),   0);
      tick();
      chk("bin.donehold", int'(done3),   1);

      // Restart from DONE in LFSR mode; start/mode toggles during RUN ignored
      start3 = 1'b1; mode3 = 2'd3;
      tick();
      start3 = 1'b0;
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("lfsr.pat%0d", k), int'(pattern3), lfsr_exp[k]);
         chk($sformatf("lfsr.idx%0d", k), int'(index3),   k);
         start3 = (k == 2 || k == 4);
         mode3  = (k >= 2) ? 2'd0 : 2'd3;
         tick();
      end
      start3 = 1'b0;
      chk("lfsr.done",  int'(done3),    1);
      chk("lfsr.final", int'(pattern3), 4);

      // Gray with backpressure at index 2
      start3 = 1'b1; mode3 = 2'd1;
      tick();
      start3 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("gray.pat%0d", k), int'(pattern3), gray_exp[k]);
         if (k == 2) begin
            ready3 = 1'b0;
            for (int h = 0; h < 3; h++) begin
               tick();
               chk($sformatf("gray.hold_pat%0d", h), int'(pattern3), 3);
               chk($sformatf("gray.hold_idx%0d", h), int'(index3),   2);
               chk($sformatf("gray.hold_vld%0d", h), int'(valid3),   1);
            end
            ready3 = 1'b1;
         end
         tick();
      end
      chk("gray.done",  int'(done3),    1);
      chk("gray.final", int'(pattern3), 4);

      // Reset mid-run at index 5 (ready high in the reset cycle)
      start3 = 1'b1; mode3 = 2'd0;
      tick();
      start3 = 1'b0;
      repeat (5) tick();
      chk("mid.idx5", int'(index3),   5);
      chk("mid.pat5", int'(pattern3), 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_idle3("mid.rst");
      tick();
      chk("mid.stay_idle", int'(valid3), 0);
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      chk("mid.restart_idx", int'(index3), 0);
      chk("mid.restart_pat", int'(pattern3), 0);
      chk("mid.restart_vld", int'(valid3), 1);
      tick();
      chk("mid.next_idx", int'(index3), 1);

      // Walking-one with a two-cycle gap between handshakes
      start4 = 1'b1; mode4 = 2'd2; ready4 = 1'b1;
      tick();
      start4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("walk.pat%0d", k), int'(pattern4), 1 << k);
         chk($sformatf("walk.vld%0d", k), int'(valid4),   1);
         tick();
         if (k < 3) begin
            for (int g = 0; g < 2; g++) begin
               chk($sformatf("walk.gap%0d_%0d", k, g), int'(valid4), 0);
               chk($sformatf("walk.gbsy%0d_%0d", k, g), int'(busy4), 1);
               tick();
            end
         end
      end
      chk("walk.done",  int'(done4),    1);
      chk("walk.final", int'(pattern4), 8);
      chk("walk.fidx",  int'(index4),   3);
      chk("walk.busy",  int'(busy4),    0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
